scoreboard_commit_queue: RTL and testbench
==========================================

Name: scoreboard_commit_queue

Overview:
- In-order circular completion queue that supplies the commit stage.
- Issue pushes decoded `scoreboard_entry_t` records and returns a transaction ID (trans_id).
- Functional-unit writeback ports complete entries by trans_id.
- The oldest NR_COMMIT_PORTS entries are presented on `commit_instr_o`. They are retired when the commit stage returns `commit_ack_i`.

Parameters:
- NR_ENTRIES, 8, queue depth; power of two, ≥ 4.
- NR_COMMIT_PORTS, 2, entries presented to commit per cycle.
- NR_WB_PORTS, 4, writeback ports.
- TRANS_ID_BITS, $clog2(NR_ENTRIES), trans_id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all entries (mispredict/exception flush).
- issue_instr_i  in  scoreboard_entry_t  entry to insert; its .valid field is ignored.
- issue_valid_i  in  1  issue request.
- issue_ack_o  out  1  entry accepted this cycle.
- issue_trans_id_o  out  TRANS_ID_BITS  slot the next accepted entry will occupy.
- wb_valid_i  in  [NR_WB_PORTS]  writeback strobe.
- wb_trans_id_i  in  [NR_WB_PORTS][TRANS_ID_BITS]  target slot.
- wb_result_i  in  [NR_WB_PORTS][64]  result data.
- wb_ex_i  in  exception_t [NR_WB_PORTS]  exception raised by the unit.
- commit_instr_o  out  scoreboard_entry_t [NR_COMMIT_PORTS]  oldest entries; .valid = occupied AND complete.
- commit_ack_i  in  [NR_COMMIT_PORTS]  retire the presented entries.
- empty_o  out  1  count == 0.
- full_o  out  1  count == NR_ENTRIES.

Behaviour:
- Reset and state:
  - On rst_i: commit_ptr = issue_ptr = 0, count = 0, all occupied/done bits = 0.
  - After reset: issue_ack_o = 0, issue_trans_id_o = 0, commit_instr_o all .valid = 0, empty_o = 1, full_o = 0.
  - Per slot: payload, occupied bit, done bit.
  - Pointers are TRANS_ID_BITS wide and wrap modulo NR_ENTRIES.
  - count is TRANS_ID_BITS+1 wide.
- Issue:
  - issue_ack_o = issue_valid_i & ~full_o & ~flush_i (combinational).
  - Decision is based on the registered count. Same-cycle commits do not free space for issue.
  - On ack: slot[issue_ptr] gets payload, occupied = 1, and issue_ptr is incremented.
  - done = issue_instr_i.ex.valid, so a fetch/decode exception completes at issue.
  - issue_trans_id_o = issue_ptr.
- Writeback:
  - For each port with wb_valid_i and occupied[wb_trans_id_i]: write result and ex, set done.
  - Writebacks to unoccupied slots are ignored.
  - Two ports targeting the same slot in one cycle: the highest-index port wins.
  - Writeback becomes visible on commit_instr_o the next cycle; there is no combinational bypass.
  - A writeback to a slot also being acked that cycle is discarded.
- Commit presentation:
  - commit_instr_o[k] = slot[(commit_ptr+k) mod NR_ENTRIES].
  - .valid = occupied & done & (k < count).
  - Purely registered-state driven: no combinational path from any input to commit_instr_o.
- Commit acknowledge:
  - Acks are prefix-only. commit_ack_i[k] is honoured only if commit_ack_i[0..k-1] are all set and commit_instr_o[k].valid.
  - Non-prefix or invalid acks are ignored; a simulation assertion flags them.
  - Each honoured ack clears occupied/done of its slot. commit_ptr advances by the number of honoured acks.
- Count:
  - count_next = count + issue_ack_o − honoured acks.
  - Simultaneous issue and commit in the same cycle are both applied.
- Flush:
  - flush_i clears all occupied/done bits, both pointers and count on the next edge.
  - Acks and writebacks in the flush cycle are discarded.
  - rst_i has priority over flush_i.
- Wrap-around: entries straddling the NR_ENTRIES−1 → 0 boundary are presented and retired in order.

Decomposition:
- Shared in ariane_pkg:
  - Existing: `scoreboard_entry_t`, `exception_t`.
  - New: a `localparam` for NR_WB_PORTS.
  - trans_id width derived from NR_SB_ENTRIES.
- No sub-module is required. Optionally, a small `popcount_prefix` helper counts honoured acks.

Test Plan:
- Reset, then issue 3 entries (pc 0x80000000/4/8), with no writeback → trans_ids 0, 1, 2; commit_instr_o[0].valid = 0; empty_o = 0.
- Write back trans_id 1, then 0, with result 0x55 → slot 1 done but not visible alone; after the second writeback, commit_instr_o[0].valid = 1 and [1].valid = 1 with result 0x55. Ack 2'b11 → count 1, commit_instr_o[0].pc = 0x80000008.
- Fill 8 entries → full_o = 1, issue_ack_o = 0 while issue_valid_i = 1. Commit 1 and issue 1 in the same cycle → issue rejected that cycle and accepted the next.
- Issue an entry with ex.valid = 1 → presented valid at commit one cycle after issue without any writeback.
- Wrap: advance pointers to 6, issue 4 entries → trans_ids 6, 7, 0, 1. Complete them out of order; commit in order 6, 7, 0, 1 across 2 cycles.
- flush_i with 5 occupied entries plus a simultaneous writeback and ack → next cycle count = 0, empty_o = 1, issue_trans_id_o = 0, commit_instr_o all invalid.

Source files
------------

// File: rtl/scoreboard_commit_queue_pkg.sv
// Shared types and sizing for the scoreboard commit queue.
//   exception_t        : exception record carried by every entry
//   scoreboard_entry_t : decoded instruction record stored per slot
//   prefix_count()     : number of honoured commit acknowledges
package scoreboard_commit_queue_pkg;

    localparam int unsigned NR_SB_ENTRIES   = 8;
    localparam int unsigned NR_ENTRIES      = NR_SB_ENTRIES;
    localparam int unsigned NR_COMMIT_PORTS = 2;
    localparam int unsigned NR_WB_PORTS     = 4;
    localparam int unsigned TRANS_ID_BITS   = $clog2(NR_SB_ENTRIES);

    typedef enum logic [3:0] {
        FU_NONE, FU_ALU, FU_LOAD, FU_STORE, FU_BRANCH, FU_CSR, FU_MULT
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

    // Honoured acks always form a contiguous prefix, so a plain popcount
    // gives how far the commit pointer moves.
    function automatic logic [TRANS_ID_BITS:0] prefix_count(
        input logic [NR_COMMIT_PORTS-1:0] ok
    );
        logic [TRANS_ID_BITS:0] n;
        n = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            n = n + (TRANS_ID_BITS+1)'(ok[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/scoreboard_commit_queue_if.sv
// Bundle of issue, writeback and commit signals of the commit queue.
// Signal names carry the queue's own direction suffixes; the "slave"
// modport is the queue, the "master" modport is the pipeline around it.
interface scoreboard_commit_queue_if import scoreboard_commit_queue_pkg::*; ();

    logic                                          flush_i;
    scoreboard_entry_t                             issue_instr_i;
    logic                                          issue_valid_i;
    logic                                          issue_ack_o;
    logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o;
    logic [NR_WB_PORTS-1:0]                        wb_valid_i;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][63:0]                  wb_result_i;
    exception_t [NR_WB_PORTS-1:0]                  wb_ex_i;
    scoreboard_entry_t [NR_COMMIT_PORTS-1:0]       commit_instr_o;
    logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i;
    logic                                          empty_o;
    logic                                          full_o;

    modport master (
        output flush_i, issue_instr_i, issue_valid_i,
        output wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_i, commit_ack_i,
        input  issue_ack_o, issue_trans_id_o, commit_instr_o, empty_o, full_o
    );

    modport slave (
        input  flush_i, issue_instr_i, issue_valid_i,
        input  wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_i, commit_ack_i,
        output issue_ack_o, issue_trans_id_o, commit_instr_o, empty_o, full_o
    );

endinterface

// File: rtl/scoreboard_commit_queue_chk.sv
// Protocol checker for the commit acknowledge: every set ack bit must be
// part of a contiguous prefix of acks and target a valid presented entry.
// Ports: clk_i, rst_i, commit_ack (from commit stage), commit_valid (queue).
module scoreboard_commit_queue_chk import scoreboard_commit_queue_pkg::*; (
    input logic                       clk_i,
    input logic                       rst_i,
    input logic [NR_COMMIT_PORTS-1:0] commit_ack,
    input logic [NR_COMMIT_PORTS-1:0] commit_valid
);

    logic ack_legal_s;
    logic prefix_s;

    // Flag any ack that is not preceded by acks on all lower ports or that hits an invalid entry
    always_comb begin
        ack_legal_s = 1'b1;
        prefix_s    = 1'b1;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            if (commit_ack[k] && !(prefix_s && commit_valid[k])) begin
                ack_legal_s = 1'b0;
            end else begin
                ack_legal_s = ack_legal_s;
            end
            prefix_s = prefix_s & commit_ack[k];
        end
    end

    ack_legal_a: assert property (@(posedge clk_i) disable iff (rst_i) ack_legal_s);

endmodule

// File: rtl/scoreboard_commit_queue.sv
// In-order circular completion queue feeding the commit stage.
// Ports: clk_i, rst_i (synchronous, active high) and sb_if (slave):
//   issue   : issue_instr_i/issue_valid_i in, issue_ack_o/issue_trans_id_o out
//   wb      : wb_valid_i/wb_trans_id_i/wb_result_i/wb_ex_i complete slots
//   commit  : commit_instr_o presents the oldest entries, commit_ack_i retires
//   status  : empty_o, full_o; flush_i discards everything
module scoreboard_commit_queue import scoreboard_commit_queue_pkg::*; (
    input logic                      clk_i,
    input logic                      rst_i,
    scoreboard_commit_queue_if.slave sb_if
);

    scoreboard_entry_t              mem_r [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]          occupied_r;
    logic [NR_ENTRIES-1:0]          done_r;
    logic [TRANS_ID_BITS-1:0]       commit_ptr_r;
    logic [TRANS_ID_BITS-1:0]       issue_ptr_r;
    logic [TRANS_ID_BITS:0]         count_r;

    logic                           full_s;
    logic                           issue_ack_s;
    scoreboard_entry_t              issue_entry_s;
    logic [TRANS_ID_BITS-1:0]       commit_idx_s [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0]     commit_valid_s;
    logic [NR_COMMIT_PORTS-1:0]     ack_ok_s;
    logic                           ack_prefix_s;
    logic [NR_ENTRIES-1:0]          retire_s;
    logic [TRANS_ID_BITS:0]         retire_cnt_s;

    // Admission uses the registered count only, so same-cycle retirement never frees space
    assign full_s                 = (count_r == (TRANS_ID_BITS+1)'(NR_ENTRIES));
    assign issue_ack_s            = sb_if.issue_valid_i & ~full_s & ~sb_if.flush_i;
    assign sb_if.issue_ack_o      = issue_ack_s;
    assign sb_if.issue_trans_id_o = issue_ptr_r;
    assign sb_if.empty_o          = (count_r == '0);
    assign sb_if.full_o           = full_s;

    // Stamp the slot id into the stored record; the stored valid bit is unused
    always_comb begin
        issue_entry_s          = sb_if.issue_instr_i;
        issue_entry_s.trans_id = issue_ptr_r;
        issue_entry_s.valid    = 1'b0;
    end

    // Present the oldest entries straight from registered state
    always_comb begin
        sb_if.commit_instr_o = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            commit_idx_s[k]   = commit_ptr_r + TRANS_ID_BITS'(k);
            commit_valid_s[k] = occupied_r[commit_idx_s[k]] & done_r[commit_idx_s[k]]
                              & ((TRANS_ID_BITS+1)'(k) < count_r);
            sb_if.commit_instr_o[k]       = mem_r[commit_idx_s[k]];
            sb_if.commit_instr_o[k].valid = commit_valid_s[k];
        end
    end

    // Honour only the contiguous run of acks on valid entries starting at port 0
    always_comb begin
        ack_prefix_s = 1'b1;
        retire_s     = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            ack_ok_s[k]  = ack_prefix_s & sb_if.commit_ack_i[k] & commit_valid_s[k];
            ack_prefix_s = ack_ok_s[k];
            retire_s[commit_idx_s[k]] = retire_s[commit_idx_s[k]] | ack_ok_s[k];
        end
        retire_cnt_s = prefix_count(ack_ok_s);
    end

    // Queue state: writeback, retirement, issue, pointers and occupancy count
    always_ff @(posedge clk_i) begin
        if (rst_i || sb_if.flush_i) begin
            occupied_r   <= '0;
            done_r       <= '0;
            commit_ptr_r <= '0;
            issue_ptr_r  <= '0;
            count_r      <= '0;
        end else begin
            // Later ports are applied last, so the highest-index port wins a collision
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (sb_if.wb_valid_i[p] && occupied_r[sb_if.wb_trans_id_i[p]]
                    && !retire_s[sb_if.wb_trans_id_i[p]]) begin
                    mem_r[sb_if.wb_trans_id_i[p]].result <= sb_if.wb_result_i[p];
                    mem_r[sb_if.wb_trans_id_i[p]].ex     <= sb_if.wb_ex_i[p];
                    done_r[sb_if.wb_trans_id_i[p]]       <= 1'b1;
                end
            end
            for (int i = 0; i < NR_ENTRIES; i++) begin
                if (retire_s[i]) begin
                    occupied_r[i] <= 1'b0;
                    done_r[i]     <= 1'b0;
                end
            end
            // The issue slot is free whenever issue is accepted, so it never meets a writeback or retire
            if (issue_ack_s) begin
                mem_r[issue_ptr_r]      <= issue_entry_s;
                occupied_r[issue_ptr_r] <= 1'b1;
                done_r[issue_ptr_r]     <= sb_if.issue_instr_i.ex.valid;
                issue_ptr_r             <= issue_ptr_r + TRANS_ID_BITS'(1);
            end
            commit_ptr_r <= commit_ptr_r + retire_cnt_s[TRANS_ID_BITS-1:0];
            count_r      <= count_r + (TRANS_ID_BITS+1)'(issue_ack_s) - retire_cnt_s;
        end
    end

    scoreboard_commit_queue_chk u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .commit_ack   (sb_if.commit_ack_i),
        .commit_valid (commit_valid_s)
    );

endmodule

// File: tb/tb_scoreboard_commit_queue.sv
// Directed self-checking bench for scoreboard_commit_queue.
module tb_scoreboard_commit_queue;
    import scoreboard_commit_queue_pkg::*;

    logic clk_i;
    logic rst_i;
    int   checks_cnt;
    int   errors_cnt;

    scoreboard_commit_queue_if sb_if ();

    scoreboard_commit_queue dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sb_if (sb_if)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic scoreboard_entry_t mk(input logic [63:0] pc, input logic exv);
        scoreboard_entry_t e;
        e          = '0;
        e.pc       = pc;
        e.fu       = FU_ALU;
        e.rd       = 5'd3;
        e.ex.valid = exv;
        e.ex.cause = exv ? 64'd2 : 64'd0;
        return e;
    endfunction

    task automatic issue_one(input logic [63:0] pc, input logic exv, input logic [63:0] exp_tid);
        sb_if.issue_instr_i = mk(pc, exv);
        sb_if.issue_valid_i = 1'b1;
        #1;
        check_eq("issue_ack", 64'(sb_if.issue_ack_o), 64'd1);
        check_eq("issue_tid", 64'(sb_if.issue_trans_id_o), exp_tid);
        tick();
        sb_if.issue_valid_i = 1'b0;
    endtask

    task automatic wb_set(input int p, input logic [63:0] tid, input logic [63:0] res);
        sb_if.wb_valid_i[p]    = 1'b1;
        sb_if.wb_trans_id_i[p] = tid[TRANS_ID_BITS-1:0];
        sb_if.wb_result_i[p]   = res;
        sb_if.wb_ex_i[p]       = '0;
    endtask

    task automatic wb_clear();
        sb_if.wb_valid_i    = '0;
        sb_if.wb_trans_id_i = '0;
        sb_if.wb_result_i   = '0;
        sb_if.wb_ex_i       = '0;
    endtask

    task automatic ack_cycle(input logic [1:0] a);
        sb_if.commit_ack_i = a;
        tick();
        sb_if.commit_ack_i = 2'b00;
    endtask

    initial begin
        checks_cnt          = 0;
        errors_cnt          = 0;
        rst_i               = 1'b1;
        sb_if.flush_i       = 1'b0;
        sb_if.issue_instr_i = '0;
        sb_if.issue_valid_i = 1'b0;
        sb_if.commit_ack_i  = 2'b00;
        wb_clear();
        tick();
        tick();
        rst_i = 1'b0;

        // reset state
        check_eq("rst_ack",   64'(sb_if.issue_ack_o), 64'd0);
        check_eq("rst_tid",   64'(sb_if.issue_trans_id_o), 64'd0);
        check_eq("rst_v0",    64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("rst_v1",    64'(sb_if.commit_instr_o[1].valid), 64'd0);
        check_eq("rst_empty", 64'(sb_if.empty_o), 64'd1);
        check_eq("rst_full",  64'(sb_if.full_o), 64'd0);

        // three issues, nothing complete
        issue_one(64'h8000_0000, 1'b0, 64'd0);
        issue_one(64'h8000_0004, 1'b0, 64'd1);
        issue_one(64'h8000_0008, 1'b0, 64'd2);
        check_eq("i3_v0",    64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("i3_empty", 64'(sb_if.empty_o), 64'd0);
        check_eq("i3_pc0",   sb_if.commit_instr_o[0].pc, 64'h8000_0000);

        // out-of-order completion: slot 1 first, head still blocked
        wb_set(0, 64'd1, 64'h55);
        tick();
        wb_clear();
        check_eq("wb1_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("wb1_v1", 64'(sb_if.commit_instr_o[1].valid), 64'd1);
        wb_set(2, 64'd0, 64'h55);
        #1;
        check_eq("wb0_nobypass", 64'(sb_if.commit_instr_o[0].valid), 64'd0);
        tick();
        wb_clear();
        check_eq("wb0_v0",  64'(sb_if.commit_instr_o[0].valid), 64'd1);
        check_eq("wb0_v1",  64'(sb_if.commit_instr_o[1].valid), 64'd1);
        check_eq("wb0_r0",  sb_if.commit_instr_o[0].result, 64'h55);
        check_eq("wb0_r1",  sb_if.commit_instr_o[1].result, 64'h55);
        check_eq("wb0_tid1", 64'(sb_if.commit_instr_o[1].trans_id), 64'd1);
        ack_cycle(2'b11);
        check_eq("ack_pc0", sb_if.commit_instr_o[0].pc, 64'h8000_0008);
        check_eq("ack_v0",  64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("ack_v1",  64'(sb_if.commit_instr_o[1].valid), 64'd0);

        // two ports hit slot 2: port 3 wins
        wb_set(0, 64'd2, 64'h11);
        wb_set(3, 64'd2, 64'h22);
        tick();
        wb_clear();
        check_eq("coll_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd1);
        check_eq("coll_r0", sb_if.commit_instr_o[0].result, 64'h22);
        ack_cycle(2'b01);
        check_eq("drain_empty", 64'(sb_if.empty_o), 64'd1);
        check_eq("drain_tid",   64'(sb_if.issue_trans_id_o), 64'd3);

        // fill the queue from slot 3 with wrap-around
        for (int i = 0; i < 8; i++) begin
            issue_one(64'h1000 + 64'(4 * i), 1'b0, 64'((3 + i) % 8));
        end
        check_eq("fill_full", 64'(sb_if.full_o), 64'd1);
        sb_if.issue_valid_i = 1'b1;
        wb_set(0, 64'd3, 64'h77);
        #1;
        check_eq("full_rej", 64'(sb_if.issue_ack_o), 64'd0);
        tick();
        wb_clear();
        // commit and issue together: issue still refused this cycle
        sb_if.commit_ack_i = 2'b01;
        #1;
        check_eq("full_rej_commit", 64'(sb_if.issue_ack_o), 64'd0);
        tick();
        sb_if.commit_ack_i = 2'b00;
        #1;
        check_eq("after_commit_ack", 64'(sb_if.issue_ack_o), 64'd1);
        check_eq("after_commit_tid", 64'(sb_if.issue_trans_id_o), 64'd3);
        check_eq("after_commit_full", 64'(sb_if.full_o), 64'd0);
        tick();
        sb_if.issue_valid_i = 1'b0;
        check_eq("refill_full", 64'(sb_if.full_o), 64'd1);
        sb_if.flush_i = 1'b1;
        tick();
        sb_if.flush_i = 1'b0;
        check_eq("fl1_empty", 64'(sb_if.empty_o), 64'd1);
        check_eq("fl1_tid",   64'(sb_if.issue_trans_id_o), 64'd0);

        // exception at issue completes the entry
        sb_if.issue_instr_i = mk(64'h2000, 1'b1);
        sb_if.issue_valid_i = 1'b1;
        #1;
        check_eq("ex_nobypass", 64'(sb_if.commit_instr_o[0].valid), 64'd0);
        tick();
        sb_if.issue_valid_i = 1'b0;
        check_eq("ex_v0",  64'(sb_if.commit_instr_o[0].valid), 64'd1);
        check_eq("ex_exv", 64'(sb_if.commit_instr_o[0].ex.valid), 64'd1);
        check_eq("ex_pc",  sb_if.commit_instr_o[0].pc, 64'h2000);
        ack_cycle(2'b01);

        // advance both pointers to 6
        for (int i = 1; i <= 5; i++) begin
            issue_one(64'h2000 + 64'(4 * i), 1'b1, 64'(i));
        end
        ack_cycle(2'b11);
        ack_cycle(2'b11);
        ack_cycle(2'b01);
        check_eq("adv_empty", 64'(sb_if.empty_o), 64'd1);

        // wrap: trans_ids 6,7,0,1
        issue_one(64'h3000, 1'b0, 64'd6);
        issue_one(64'h3004, 1'b0, 64'd7);
        issue_one(64'h3008, 1'b0, 64'd0);
        issue_one(64'h300C, 1'b0, 64'd1);
        wb_set(1, 64'd0, 64'hA0);
        wb_set(2, 64'd1, 64'hA1);
        tick();
        wb_clear();
        check_eq("wr_a_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("wr_a_v1", 64'(sb_if.commit_instr_o[1].valid), 64'd0);
        wb_set(0, 64'd7, 64'hB7);
        tick();
        wb_clear();
        check_eq("wr_b_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("wr_b_v1", 64'(sb_if.commit_instr_o[1].valid), 64'd1);
        wb_set(3, 64'd6, 64'hB6);
        tick();
        wb_clear();
        check_eq("wr_c_r0", sb_if.commit_instr_o[0].result, 64'hB6);
        check_eq("wr_c_r1", sb_if.commit_instr_o[1].result, 64'hB7);
        check_eq("wr_c_v",  64'({sb_if.commit_instr_o[1].valid, sb_if.commit_instr_o[0].valid}), 64'd3);
        ack_cycle(2'b11);
        check_eq("wr_d_pc0", sb_if.commit_instr_o[0].pc, 64'h3008);
        check_eq("wr_d_pc1", sb_if.commit_instr_o[1].pc, 64'h300C);
        check_eq("wr_d_r0",  sb_if.commit_instr_o[0].result, 64'hA0);
        check_eq("wr_d_v",   64'({sb_if.commit_instr_o[1].valid, sb_if.commit_instr_o[0].valid}), 64'd3);
        ack_cycle(2'b11);
        check_eq("wr_empty", 64'(sb_if.empty_o), 64'd1);
        check_eq("wr_tid",   64'(sb_if.issue_trans_id_o), 64'd2);

        // writeback to a free slot is ignored
        wb_set(0, 64'd2, 64'h99);
        tick();
        wb_clear();
        issue_one(64'h4000, 1'b0, 64'd2);
        check_eq("unocc_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd0);

        // flush with 5 occupied plus wb, ack and issue in the same cycle
        for (int i = 0; i < 4; i++) begin
            issue_one(64'h4004 + 64'(4 * i), 1'b0, 64'(3 + i));
        end
        wb_set(0, 64'd2, 64'h12);
        tick();
        wb_clear();
        check_eq("pre_fl_v0", 64'(sb_if.commit_instr_o[0].valid), 64'd1);
        sb_if.flush_i       = 1'b1;
        sb_if.commit_ack_i  = 2'b01;
        sb_if.issue_valid_i = 1'b1;
        sb_if.issue_instr_i = mk(64'h6000, 1'b1);
        wb_set(1, 64'd3, 64'h34);
        #1;
        check_eq("fl_issue_rej", 64'(sb_if.issue_ack_o), 64'd0);
        tick();
        sb_if.flush_i       = 1'b0;
        sb_if.commit_ack_i  = 2'b00;
        sb_if.issue_valid_i = 1'b0;
        wb_clear();
        check_eq("fl_empty", 64'(sb_if.empty_o), 64'd1);
        check_eq("fl_full",  64'(sb_if.full_o), 64'd0);
        check_eq("fl_tid",   64'(sb_if.issue_trans_id_o), 64'd0);
        check_eq("fl_v",     64'({sb_if.commit_instr_o[1].valid, sb_if.commit_instr_o[0].valid}), 64'd0);
        issue_one(64'h5000, 1'b0, 64'd0);
        check_eq("post_fl_v0",  64'(sb_if.commit_instr_o[0].valid), 64'd0);
        check_eq("post_fl_pc0", sb_if.commit_instr_o[0].pc, 64'h5000);
        check_eq("post_fl_tid", 64'(sb_if.issue_trans_id_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
